reg_bank_s8_ctrl: RTL and testbench

Command-level master for the 8-entry, 8-bit register bank (RegBankS8). It accepts host commands over a valid/ready handshake and turns them into the bank's 12-bit instruction stream: single-register write, clear-all, and a pipelined snapshot. The snapshot issues RDO for registers 0..7 and assembles the bank's `out` values into one 64-bit word. It sits between a host/sequencer and the RegBankS8 `inst`/`inst_en`/`out` pins.

---
 rtl/reg_bank_s8_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_reg_bank_s8_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_s8_ctrl.sv
// -----------------------------------------------------------------------------
// reg_bank_s8_ctrl
//
// Command-level master for the 8-entry x 8-bit register bank (RegBankS8).
// Host commands arrive over a valid/ready handshake. They are turned into the
// bank's 12-bit instruction stream {opcode[3:0], imm[7:0]}.
//
// Commands (cmd_op):
//   00 write      : one LDidx instruction carrying cmd_data
//   01 snapshot   : RDO 0..7 back to back; rb_out is captured into a shadow
//                   word, which is then published on snap with a snap_valid pulse
//   10 clear-all  : LD0..LD7 with imm 8'h00
//   11 illegal    : one-cycle cmd_err pulse, nothing is sent to the bank
//
// Handshake: a command is accepted on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_op/cmd_idx/cmd_data are sampled only on that
// edge. cmd_ready is registered and is high only while idle. cmd_valid is
// ignored at all other times.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   cmd_valid   in   host command present
//   cmd_ready   out  controller idle, command will be accepted
//   cmd_op      in   [1:0] opcode
//   cmd_idx     in   [2:0] register index (write)
//   cmd_data    in   [7:0] register data (write)
//   rb_inst     out  [11:0] instruction to bank
//   rb_inst_en  out  instruction enable to bank
//   rb_out      in   [7:0] bank read data
//   snap        out  [63:0] last completed snapshot, byte k = register k
//   snap_valid  out  one-cycle pulse, snap just updated
//   cmd_err     out  one-cycle pulse, illegal opcode accepted
//   dbg_state   out  [2:0] current FSM state (observation only)
//
// Parameter ReadLatency (1..4): number of cycles from the cycle an RDO is
// driven to the cycle whose end has rb_out holding that register.
// -----------------------------------------------------------------------------

`ifndef RegBankS8_NOP
`define RegBankS8_NOP 4'h0
`define RegBankS8_LD0 4'h1
`define RegBankS8_LD1 4'h2
`define RegBankS8_LD2 4'h3
`define RegBankS8_LD3 4'h4
`define RegBankS8_LD4 4'h5
`define RegBankS8_LD5 4'h6
`define RegBankS8_LD6 4'h7
`define RegBankS8_LD7 4'h8
`define RegBankS8_RDO 4'h9
`endif

module reg_bank_s8_ctrl #(
    parameter int ReadLatency = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_idx,
    input  logic [7:0]  cmd_data,
    output logic [11:0] rb_inst,
    output logic        rb_inst_en,
    input  logic [7:0]  rb_out,
    output logic [63:0] snap,
    output logic        snap_valid,
    output logic        cmd_err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_CLEAR = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [11:0] InstNop = {`RegBankS8_NOP, 8'h00};

    state_t      r_state;
    logic        r_cmd_ready;
    logic [11:0] r_inst;
    logic        r_inst_en;
    logic [63:0] r_snap;
    logic        r_snap_valid;
    logic        r_cmd_err;
    logic [2:0]  r_cnt;

    // Capture pipeline: stage 0 is loaded at the end of each RDO cycle, and
    // the last stage names the byte whose data sits on rb_out in this cycle.
    logic [ReadLatency-1:0] r_cap_v;
    logic [2:0]             r_cap_idx [ReadLatency];
    logic [63:0]            r_shadow;

    logic        w_rdo_issue;
    logic        w_cap_fire;
    logic [2:0]  w_cap_idx;
    logic [63:0] w_shadow_next;
    logic [2:0]  w_cnt_inc;

    function automatic logic [3:0] ld_opcode(input logic [2:0] idx);
        logic [3:0] op;
        case (idx)
            3'd0:    op = `RegBankS8_LD0;
            3'd1:    op = `RegBankS8_LD1;
            3'd2:    op = `RegBankS8_LD2;
            3'd3:    op = `RegBankS8_LD3;
            3'd4:    op = `RegBankS8_LD4;
            3'd5:    op = `RegBankS8_LD5;
            3'd6:    op = `RegBankS8_LD6;
            default: op = `RegBankS8_LD7;
        endcase
        return op;
    endfunction

    // Derived from the registered instruction outputs, so the pipeline tracks
    // exactly what the bank was shown.
    assign w_rdo_issue = r_inst_en && (r_inst[11:8] == `RegBankS8_RDO);
    assign w_cap_fire  = r_cap_v[ReadLatency-1];
    assign w_cap_idx   = r_cap_idx[ReadLatency-1];
    assign w_cnt_inc   = r_cnt + 3'd1;

    // rb_out is looked at only when a capture is due, so junk on it at
    // other times never reaches the shadow.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_cap_fire) begin
            w_shadow_next[{w_cap_idx, 3'b000} +: 8] = rb_out;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cap_v  <= '0;
            r_shadow <= 64'h0;
            for (int i = 0; i < ReadLatency; i++) begin
                r_cap_idx[i] <= 3'd0;
            end
        end else begin
            r_cap_v[0]   <= w_rdo_issue;
            r_cap_idx[0] <= r_inst[2:0];
            for (int i = 1; i < ReadLatency; i++) begin
                r_cap_v[i]   <= r_cap_v[i-1];
                r_cap_idx[i] <= r_cap_idx[i-1];
            end
            r_shadow <= w_shadow_next;
        end
    end

    // Control FSM. All outputs are registered: the value loaded on an edge is
    // what the bank/host sees for the whole following cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_inst       <= InstNop;
            r_inst_en    <= 1'b0;
            r_snap       <= 64'h0;
            r_snap_valid <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_cnt        <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready  <= 1'b1;
                    r_inst       <= InstNop;
                    r_inst_en    <= 1'b0;
                    r_snap_valid <= 1'b0;
                    r_cmd_err    <= 1'b0;
                    // r_cmd_ready is low on the first edge after reset, so
                    // nothing is accepted until the host has seen ready.
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_cnt       <= 3'd0;
                        case (cmd_op)
                            2'b00: begin
                                r_state   <= S_WRITE;
                                r_inst    <= {ld_opcode(cmd_idx), cmd_data};
                                r_inst_en <= 1'b1;
                            end
                            2'b01: begin
                                r_state   <= S_READ;
                                r_inst    <= {`RegBankS8_RDO, 8'h00};
                                r_inst_en <= 1'b1;
                            end
                            2'b10: begin
                                r_state   <= S_CLEAR;
                                r_inst    <= {`RegBankS8_LD0, 8'h00};
                                r_inst_en <= 1'b1;
                            end
                            default: begin
                                r_state   <= S_ERR;
                                r_cmd_err <= 1'b1;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    r_state     <= S_IDLE;
                    r_inst      <= InstNop;
                    r_inst_en   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end

                S_CLEAR: begin
                    if (r_cnt == 3'd7) begin
                        r_state     <= S_IDLE;
                        r_inst      <= InstNop;
                        r_inst_en   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_inst <= {ld_opcode(w_cnt_inc), 8'h00};
                    end
                end

                S_READ: begin
                    if (r_cnt == 3'd7) begin
                        r_state   <= S_DRAIN;
                        r_inst    <= InstNop;
                        r_inst_en <= 1'b0;
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_inst <= {`RegBankS8_RDO, 5'b0, w_cnt_inc};
                    end
                end

                S_DRAIN: begin
                    // Byte 7 is captured on this same edge, so snap takes the
                    // shadow value including it: a partial word never shows.
                    if (w_cap_fire && (w_cap_idx == 3'd7)) begin
                        r_state      <= S_DONE;
                        r_snap       <= w_shadow_next;
                        r_snap_valid <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_snap_valid <= 1'b0;
                    r_cmd_ready  <= 1'b1;
                end

                S_ERR: begin
                    r_state     <= S_IDLE;
                    r_cmd_err   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_inst      <= InstNop;
                    r_inst_en   <= 1'b0;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rb_inst    = r_inst;
    assign rb_inst_en = r_inst_en;
    assign snap       = r_snap;
    assign snap_valid = r_snap_valid;
    assign cmd_err    = r_cmd_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_reg_bank_s8_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_s8_ctrl
//
// Two controllers share clock, reset and command fields: u_dut1 with
// ReadLatency=1 and u_dut3 with ReadLatency=3. Each one drives its own small
// RegBankS8 model. Only one of them is commanded at a time. The driver pushes
// the expected instructions, snapshots and error pulses (each tagged with the
// DUT and the cycle) into queues. A negedge monitor pops and compares
// whenever a DUT shows rb_inst_en, snap_valid or cmd_err.
// -----------------------------------------------------------------------------

`ifndef RegBankS8_NOP
`define RegBankS8_NOP 4'h0
`define RegBankS8_LD0 4'h1
`define RegBankS8_LD1 4'h2
`define RegBankS8_LD2 4'h3
`define RegBankS8_LD3 4'h4
`define RegBankS8_LD4 4'h5
`define RegBankS8_LD5 4'h6
`define RegBankS8_LD6 4'h7
`define RegBankS8_LD7 4'h8
`define RegBankS8_RDO 4'h9
`endif

module tb_reg_bank_s8_ctrl;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        cmd_valid1 = 1'b0, cmd_valid3 = 1'b0;
    logic [1:0]  cmd_op   = 2'b00;
    logic [2:0]  cmd_idx  = 3'd0;
    logic [7:0]  cmd_data = 8'h00;

    logic        ready1, en1, sv1, err1;
    logic [11:0] inst1;
    logic [63:0] snap1;
    logic [7:0]  rbout1;
    logic [2:0]  st1;

    logic        ready3, en3, sv3, err3;
    logic [11:0] inst3;
    logic [63:0] snap3;
    logic [7:0]  rbout3;
    logic [2:0]  st3;

    reg_bank_s8_ctrl #(.ReadLatency(1)) u_dut1 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(ready1),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
        .rb_inst(inst1), .rb_inst_en(en1), .rb_out(rbout1),
        .snap(snap1), .snap_valid(sv1), .cmd_err(err1), .dbg_state(st1)
    );

    reg_bank_s8_ctrl #(.ReadLatency(3)) u_dut3 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(ready3),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
        .rb_inst(inst3), .rb_inst_en(en3), .rb_out(rbout3),
        .snap(snap3), .snap_valid(sv3), .cmd_err(err3), .dbg_state(st3)
    );

    // ---------------- bank models ----------------
    // RDO in cycle c puts the register on rb_out for cycle c+latency.
    // Outside those cycles the models drive 8'hEE as junk.
    logic [7:0] regs1 [8];
    logic [7:0] regs3 [8];
    logic [7:0] p1;
    logic [7:0] p3 [3];
    wire  [3:0] k1 = inst1[11:8] - `RegBankS8_LD0;
    wire  [3:0] k3 = inst3[11:8] - `RegBankS8_LD0;

    initial begin
        for (int i = 0; i < 8; i++) begin
            regs1[i] = 8'h00;
            regs3[i] = 8'h00;
        end
        p1 = 8'hEE;
        for (int i = 0; i < 3; i++) p3[i] = 8'hEE;
    end

    always @(posedge clock) begin
        if (en1 && inst1[11:8] >= `RegBankS8_LD0 && inst1[11:8] <= `RegBankS8_LD7)
            regs1[k1[2:0]] <= inst1[7:0];
        p1 <= (en1 && inst1[11:8] == `RegBankS8_RDO) ? regs1[inst1[2:0]] : 8'hEE;
        if (en3 && inst3[11:8] >= `RegBankS8_LD0 && inst3[11:8] <= `RegBankS8_LD7)
            regs3[k3[2:0]] <= inst3[7:0];
        p3[0] <= (en3 && inst3[11:8] == `RegBankS8_RDO) ? regs3[inst3[2:0]] : 8'hEE;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rbout1 = p1;
    assign rbout3 = p3[2];

    // ---------------- scoreboard ----------------
    logic [44:0] exp_inst_q [$];   // {dut, cycle[31:0], inst[11:0]}
    logic [96:0] exp_snap_q [$];   // {dut, cycle[31:0], snap[63:0]}
    logic [32:0] exp_err_q  [$];   // {dut, cycle[31:0]}

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic d);
        total++;
        bad++;
        $display("FAIL %s: output seen on dut%0d at cycle %0d with nothing expected",
                 name, d ? 3 : 1, cyc);
    endtask

    task automatic mon(input logic d, input logic en, input logic [11:0] inst,
                       input logic sv, input logic [63:0] sn, input logic er);
        logic [44:0] ei;
        logic [96:0] es;
        logic [32:0] ee;
        if (en) begin
            if (exp_inst_q.size() == 0) unexpected("inst", d);
            else begin
                ei = exp_inst_q.pop_front();
                check("inst{dut,cyc,inst}", {83'h0, d, 32'(cyc), inst}, {83'h0, ei});
            end
        end
        if (sv) begin
            if (exp_snap_q.size() == 0) unexpected("snap_valid", d);
            else begin
                es = exp_snap_q.pop_front();
                check("snap_valid{dut,cyc}", {95'h0, d, 32'(cyc)}, {95'h0, es[96:64]});
                check("snap", {64'h0, sn}, {64'h0, es[63:0]});
            end
        end
        if (er) begin
            if (exp_err_q.size() == 0) unexpected("cmd_err", d);
            else begin
                ee = exp_err_q.pop_front();
                check("cmd_err{dut,cyc}", {95'h0, d, 32'(cyc)}, {95'h0, ee});
            end
        end
    endtask

    always @(negedge clock) begin
        mon(1'b0, en1, inst1, sv1, snap1, err1);
        mon(1'b1, en3, inst3, sv3, snap3, err3);
    end

    // ---------------- driver ----------------
    // Issues one command to dut1 (d=0) or dut3 (d=1), pushes its expectations
    // and, if asked, waits for cmd_ready and checks the cycle it came back.
    task automatic send(input logic d, input logic [1:0] op, input logic [2:0] idx,
                        input logic [7:0] data, input logic [63:0] exp_snap,
                        input bit wait_ready, output int acc);
        int n;
        int lat;
        int rdy_off;
        lat = d ? 3 : 1;
        acc = 0;
        @(negedge clock);
        cmd_op   = op;
        cmd_idx  = idx;
        cmd_data = data;
        if (d) cmd_valid3 = 1'b1; else cmd_valid1 = 1'b1;
        n = 0;
        while (!(d ? ready3 : ready1) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: cmd_ready low for %0d cycles, want high", n);
            cmd_valid1 = 1'b0;
            cmd_valid3 = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        cmd_valid1 = 1'b0;
        cmd_valid3 = 1'b0;
        acc = cyc;   // cyc of command cycle 1
        case (op)
            2'b00: begin
                exp_inst_q.push_back({d, 32'(acc), `RegBankS8_LD0 + {1'b0, idx}, data});
                rdy_off = 1;
            end
            2'b01: begin
                for (int k = 0; k < 8; k++)
                    exp_inst_q.push_back({d, 32'(acc + k), `RegBankS8_RDO, 5'b0, 3'(k)});
                exp_snap_q.push_back({d, 32'(acc + 8 + lat), exp_snap});
                rdy_off = 9 + lat;
            end
            2'b10: begin
                for (int k = 0; k < 8; k++)
                    exp_inst_q.push_back({d, 32'(acc + k), `RegBankS8_LD0 + 4'(k), 8'h00});
                rdy_off = 8;
            end
            default: begin
                exp_err_q.push_back({d, 32'(acc)});
                rdy_off = 1;
            end
        endcase
        if (wait_ready) begin
            n = 0;
            @(negedge clock);
            while (!(d ? ready3 : ready1) && n < 60) begin
                @(negedge clock);
                n++;
            end
            check("cmd_ready_return_cycle", 128'(cyc), 128'(acc + rdy_off));
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] wv [8] = '{8'hAE, 8'hAB, 8'hEF, 8'h2F, 8'h72, 8'h3E, 8'h92, 8'h61};
    localparam logic [63:0] SnapAll = 64'h61923E722FEFABAE;

    initial begin
        int a;
        // Reset values
        #1;
        check("rst_ready",  {127'h0, ready1}, 128'h0);
        check("rst_inst",   {116'h0, inst1},  {116'h0, `RegBankS8_NOP, 8'h00});
        check("rst_en",     {127'h0, en1},    128'h0);
        check("rst_snap",   {64'h0, snap1},   128'h0);
        check("rst_flags",  {125'h0, sv1, err1, en3}, 128'h0);
        check("rst_state",  {125'h0, st1},    128'h0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_release", {126'h0, ready1, ready3}, 128'h3);

        // Writes idx 0..7, snapshot, latency 1
        for (int k = 0; k < 8; k++) send(1'b0, 2'b00, 3'(k), wv[k], 64'h0, 1'b1, a);
        send(1'b0, 2'b01, 3'd0, 8'h00, SnapAll, 1'b1, a);

        // Illegal opcode, bank untouched
        send(1'b0, 2'b11, 3'd5, 8'hAB, 64'h0, 1'b1, a);
        send(1'b0, 2'b01, 3'd0, 8'h00, SnapAll, 1'b1, a);

        // Reset in READ cycle 4
        send(1'b0, 2'b01, 3'd0, 8'h00, SnapAll, 1'b0, a);
        while (cyc < a + 3) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_en",    {127'h0, en1},    128'h0);
        check("midrst_snap",  {64'h0, snap1},   128'h0);
        check("midrst_ready", {127'h0, ready1}, 128'h0);
        exp_inst_q.delete();
        exp_snap_q.delete();
        exp_err_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        send(1'b0, 2'b00, 3'd0, 8'h1A, 64'h0, 1'b1, a);
        send(1'b0, 2'b01, 3'd0, 8'h00, 64'h61923E722FEFAB1A, 1'b1, a);

        // Clear-all then snapshot
        send(1'b0, 2'b10, 3'd0, 8'h00, 64'h0, 1'b1, a);
        send(1'b0, 2'b01, 3'd0, 8'h00, 64'h0, 1'b1, a);

        // Latency 3 controller
        for (int k = 0; k < 8; k++) send(1'b1, 2'b00, 3'(k), wv[k], 64'h0, 1'b1, a);
        send(1'b1, 2'b01, 3'd0, 8'h00, SnapAll, 1'b1, a);

        repeat (6) @(negedge clock);
        check("leftover_inst", 128'(exp_inst_q.size()), 128'h0);
        check("leftover_snap", 128'(exp_snap_q.size()), 128'h0);
        check("leftover_err",  128'(exp_err_q.size()),  128'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
